io_frame_scheduler: RTL and testbench

//  Frame-level scheduler for the front-panel I/O sequencer (IN-12 cathode/anode, keyboard, MS6205 writes).

---
 rtl/io_frame_scheduler_if.sv | 48 ++++
 rtl/io_frame_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_io_frame_scheduler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/io_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : io_frame_scheduler_if
// Purpose  : Bundles the sequencer handshake, the MS6205 requester bus and the
//            frame status outputs of io_frame_scheduler.
//   seq_state        sequencer state from the I/O sequencer (NONE=0, STOP=7)
//   seq_enable       frame enable to the sequencer
//   ms6205_*         granted write flags and payload
//   req_*            per-requester write requests and done pulses
//   frame_strobe     1-cycle pulse at frame start
//   anode_index      current IN-12 anode scan index
//   timeout_err      sticky watchdog abort flag
// master : scheduler side.   slave : requesters and sequencer side.
// Revision : 1.0  initial release
// ============================================================================
interface io_frame_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [2:0]              seq_state;
  logic                    seq_enable;
  logic                    ms6205_addr_acq;
  logic                    ms6205_data_acq;
  logic [ADDR_W-1:0]       ms6205_addr;
  logic [DATA_W-1:0]       ms6205_data;
  logic [N_REQ-1:0]        req_addr_valid;
  logic [N_REQ-1:0]        req_data_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_done;
  logic                    frame_strobe;
  logic [3:0]              anode_index;
  logic                    timeout_err;

  modport master (
    input  seq_state, req_addr_valid, req_data_valid, req_addr, req_data,
    output seq_enable, ms6205_addr_acq, ms6205_data_acq, ms6205_addr,
           ms6205_data, req_done, frame_strobe, anode_index, timeout_err
  );

  modport slave (
    output seq_state, req_addr_valid, req_data_valid, req_addr, req_data,
    input  seq_enable, ms6205_addr_acq, ms6205_data_acq, ms6205_addr,
           ms6205_data, req_done, frame_strobe, anode_index, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/io_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : io_frame_scheduler
// Purpose  : Opens one I/O sequencer frame at a time, round-robin grants one
//            MS6205 write request per frame, advances the IN-12 anode scan
//            once per completed frame, and aborts stuck frames by watchdog.
// Ports    : Clock_1us  1 MHz clock, posedge
//            Rst_n      asynchronous active-low reset
//            bus        io_frame_scheduler_if.master (sequencer, MS6205,
//                       requester and status signals)
// Revision : 1.0  initial release
// ============================================================================
module io_frame_scheduler #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int IDLE_CYC = 64,
  parameter int TIMEOUT  = 255,
  parameter int N_ANODES = 10
) (
  input wire                   Clock_1us,
  input wire                   Rst_n,
  io_frame_scheduler_if.master bus
);

  localparam int C_GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int C_IW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam int C_WW = $clog2(TIMEOUT + 1);

  localparam logic [C_IW-1:0] C_IDLE_RELOAD = C_IW'(IDLE_CYC - 1);
  localparam logic [C_WW-1:0] C_WD_LAST     = C_WW'(TIMEOUT - 1);
  localparam logic [C_GW-1:0] C_LAST_REQ    = C_GW'(N_REQ - 1);
  localparam logic [3:0]      C_LAST_ANODE  = 4'(N_ANODES - 1);
  localparam logic [2:0]      C_SEQ_NONE    = 3'd0;
  localparam logic [2:0]      C_SEQ_STOP    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q,     state_d;
  logic [C_IW-1:0]   idle_cnt_q,  idle_cnt_d;
  logic [C_WW-1:0]   wd_cnt_q,    wd_cnt_d;
  logic [C_GW-1:0]   rr_q,        rr_d;
  logic [C_GW-1:0]   grant_q,     grant_d;
  logic              grant_vld_q, grant_vld_d;
  logic              addr_acq_q,  addr_acq_d;
  logic              data_acq_q,  data_acq_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] data_q,      data_d;
  logic              strobe_q,    strobe_d;
  logic [3:0]        anode_q,     anode_d;
  logic              terr_q,      terr_d;

  logic [N_REQ-1:0]  w_active;
  logic              w_found;
  logic [C_GW-1:0]   w_pick;
  logic [N_REQ-1:0]  w_done;

  assign w_active = bus.req_addr_valid | bus.req_data_valid;

  // Round-robin search: first active requester at or above rr_q, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = rr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_active[(int'(rr_q) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_pick  = C_GW'((int'(rr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    grant_vld_d = grant_vld_q;
    addr_acq_d  = addr_acq_q;
    data_acq_d  = data_acq_q;
    addr_d      = addr_q;
    data_d      = data_q;
    strobe_d    = 1'b0;
    anode_d     = anode_q;
    terr_d      = terr_q;

    case (state_q)
      S_IDLE: begin
        if (idle_cnt_q == '0) begin
          state_d = S_LATCH;
        end else begin
          idle_cnt_d = idle_cnt_q - C_IW'(1);
        end
      end

      S_LATCH: begin
        // Requests are only sampled here; payload is held when nobody asks.
        grant_vld_d = w_found;
        if (w_found) begin
          grant_d    = w_pick;
          addr_d     = bus.req_addr[int'(w_pick)*ADDR_W +: ADDR_W];
          data_d     = bus.req_data[int'(w_pick)*DATA_W +: DATA_W];
          addr_acq_d = bus.req_addr_valid[w_pick];
          data_acq_d = bus.req_data_valid[w_pick];
        end else begin
          addr_acq_d = 1'b0;
          data_acq_d = 1'b0;
        end
        wd_cnt_d = '0;
        strobe_d = 1'b1;
        state_d  = S_RUN;
      end

      S_RUN, S_DRAIN: begin
        wd_cnt_d = wd_cnt_q + C_WW'(1);
        // Watchdog has priority over a normal sequencer transition.
        if (wd_cnt_q == C_WD_LAST) begin
          terr_d      = 1'b1;
          addr_acq_d  = 1'b0;
          data_acq_d  = 1'b0;
          grant_vld_d = 1'b0;
          idle_cnt_d  = C_IDLE_RELOAD;
          state_d     = S_IDLE;
        end else if (state_q == S_RUN && bus.seq_state == C_SEQ_STOP) begin
          state_d = S_DRAIN;
        end else if (state_q == S_DRAIN && bus.seq_state == C_SEQ_NONE) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (grant_vld_q) begin
          rr_d = (grant_q == C_LAST_REQ) ? '0 : grant_q + C_GW'(1);
        end
        anode_d     = (anode_q == C_LAST_ANODE) ? 4'd0 : anode_q + 4'd1;
        addr_acq_d  = 1'b0;
        data_acq_d  = 1'b0;
        grant_vld_d = 1'b0;
        idle_cnt_d  = C_IDLE_RELOAD;
        state_d     = S_IDLE;
      end

      default: begin
        idle_cnt_d = C_IDLE_RELOAD;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock_1us or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      idle_cnt_q  <= C_IDLE_RELOAD;
      wd_cnt_q    <= '0;
      rr_q        <= '0;
      grant_q     <= '0;
      grant_vld_q <= 1'b0;
      addr_acq_q  <= 1'b0;
      data_acq_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      strobe_q    <= 1'b0;
      anode_q     <= 4'd0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      grant_vld_q <= grant_vld_d;
      addr_acq_q  <= addr_acq_d;
      data_acq_q  <= data_acq_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      anode_q     <= anode_d;
      terr_q      <= terr_d;
    end
  end

  // Done pulse is decoded from state so it lasts exactly the DONE cycle.
  always_comb begin
    w_done = '0;
    if (state_q == S_DONE && grant_vld_q) begin
      w_done[grant_q] = 1'b1;
    end
  end

  // Enable follows state directly so an asynchronous reset drops it at once.
  assign bus.seq_enable      = (state_q == S_RUN);
  assign bus.ms6205_addr_acq = addr_acq_q;
  assign bus.ms6205_data_acq = data_acq_q;
  assign bus.ms6205_addr     = addr_q;
  assign bus.ms6205_data     = data_q;
  assign bus.req_done        = w_done;
  assign bus.frame_strobe    = strobe_q;
  assign bus.anode_index     = anode_q;
  assign bus.timeout_err     = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_io_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_frame_scheduler
// Purpose  : Directed self-checking bench for io_frame_scheduler.
// Revision : 1.0  initial release
// ============================================================================
module tb_io_frame_scheduler;
  localparam int N_REQ    = 4;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;
  localparam int IDLE_CYC = 8;
  localparam int TIMEOUT  = 20;
  localparam int N_ANODES = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  io_frame_scheduler_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  io_frame_scheduler #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .IDLE_CYC(IDLE_CYC), .TIMEOUT(TIMEOUT), .N_ANODES(N_ANODES)
  ) dut (
    .Clock_1us(clk),
    .Rst_n    (rst_n),
    .bus      (bif.master)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_anode = 0;

  int         f_wait;
  logic [1:0] f_acq;
  logic [7:0] f_addr, f_data, f_addr_late;
  logic [3:0] f_done_or;
  int         f_done_cyc;
  logic       f_strobe_ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic av, input logic dv,
                         input logic [7:0] a, input logic [7:0] d);
    bif.req_addr_valid[i]    = av;
    bif.req_data_valid[i]    = dv;
    bif.req_addr[i*8 +: 8]   = a;
    bif.req_data[i*8 +: 8]   = d;
  endtask

  // One frame with a well-behaved sequencer: STOP stop_after cycles after
  // enable, back to NONE one cycle after enable drops.
  task automatic do_frame(input int stop_after, input logic poke);
    logic s_first;
    int   t;
    f_wait = 0;
    while (bif.seq_enable !== 1'b1 && f_wait < 200) begin
      @(negedge clk);
      f_wait++;
    end
    chk("enable_seen", 32'(bif.seq_enable), 32'd1);
    s_first = bif.frame_strobe;
    bif.seq_state = 3'd3;
    @(negedge clk);
    f_strobe_ok = (s_first === 1'b1) && (bif.frame_strobe === 1'b0);
    f_acq  = {bif.ms6205_addr_acq, bif.ms6205_data_acq};
    f_addr = bif.ms6205_addr;
    f_data = bif.ms6205_data;
    for (int i = 1; i < stop_after; i++) begin
      if (poke && i == 2) bif.req_addr[2*8 +: 8] = 8'h11;
      @(negedge clk);
    end
    f_addr_late = bif.ms6205_addr;
    bif.seq_state = 3'd7;
    t = 0;
    while (bif.seq_enable === 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("drain_entered", 32'(bif.seq_enable), 32'd0);
    @(negedge clk);
    bif.seq_state = 3'd0;
    f_done_or  = 4'd0;
    f_done_cyc = 0;
    repeat (3) begin
      @(negedge clk);
      f_done_or = f_done_or | bif.req_done;
      if (bif.req_done != 4'd0) f_done_cyc++;
    end
  endtask

  task automatic check_frame(input string tag, input logic [1:0] e_acq,
                             input logic [7:0] e_addr, input logic [7:0] e_data,
                             input logic [3:0] e_done);
    exp_anode = (exp_anode + 1) % N_ANODES;
    chk({tag, "_acq"},      32'(f_acq),       32'(e_acq));
    chk({tag, "_addr"},     32'(f_addr),      32'(e_addr));
    chk({tag, "_data"},     32'(f_data),      32'(e_data));
    chk({tag, "_addr_hold"},32'(f_addr_late), 32'(e_addr));
    chk({tag, "_done"},     32'(f_done_or),   32'(e_done));
    chk({tag, "_done_len"}, 32'(f_done_cyc),  (e_done != 4'd0) ? 32'd1 : 32'd0);
    chk({tag, "_strobe"},   32'(f_strobe_ok), 32'd1);
    chk({tag, "_anode"},    32'(bif.anode_index), 32'(exp_anode));
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  initial begin
    int          hi_cnt;
    logic [3:0]  done_seen;
    int          gnt [6];
    logic [1:0]  rr_acq [4];

    rst_n = 1'b0;
    bif.seq_state      = 3'd0;
    bif.req_addr_valid = '0;
    bif.req_data_valid = '0;
    bif.req_addr       = '0;
    bif.req_data       = '0;

    // Reset values
    #12;
    chk("rst_enable", 32'(bif.seq_enable),      32'd0);
    chk("rst_acq",    32'({bif.ms6205_addr_acq, bif.ms6205_data_acq}), 32'd0);
    chk("rst_addr",   32'(bif.ms6205_addr),     32'd0);
    chk("rst_data",   32'(bif.ms6205_data),     32'd0);
    chk("rst_done",   32'(bif.req_done),        32'd0);
    chk("rst_strobe", 32'(bif.frame_strobe),    32'd0);
    chk("rst_anode",  32'(bif.anode_index),     32'd0);
    chk("rst_terr",   32'(bif.timeout_err),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Eleven empty frames: anode 1..9, 0, 1; first frame after IDLE_CYC+1
    for (int k = 0; k < 11; k++) begin
      do_frame(5, 1'b0);
      if (k == 0) chk("first_gap", 32'(f_wait), 32'(IDLE_CYC + 1));
      check_frame("empty", 2'b00, 8'h00, 8'h00, 4'd0);
    end

    // Requesters 0, 2, 3 held: grant order 0,2,3,0,2,3
    set_req(0, 1'b1, 1'b0, 8'h10, 8'h20);
    set_req(2, 1'b0, 1'b1, 8'h12, 8'h22);
    set_req(3, 1'b1, 1'b1, 8'h13, 8'h23);
    gnt = '{0, 2, 3, 0, 2, 3};
    rr_acq = '{2'b10, 2'b00, 2'b01, 2'b11};
    for (int k = 0; k < 6; k++) begin
      do_frame(5, 1'b0);
      check_frame("rr", rr_acq[gnt[k]], 8'(8'h10 + gnt[k]), 8'(8'h20 + gnt[k]),
                  4'(1 << gnt[k]));
    end
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(2, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(3, 1'b0, 1'b0, 8'h00, 8'h00);

    // Requester 1 with both writes
    set_req(1, 1'b1, 1'b1, 8'h3A, 8'h55);
    do_frame(5, 1'b0);
    check_frame("req1", 2'b11, 8'h3A, 8'h55, 4'b0010);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Requester 2 address only; address input changes mid-frame
    set_req(2, 1'b1, 1'b0, 8'h44, 8'h99);
    do_frame(5, 1'b1);
    check_frame("req2_hold", 2'b10, 8'h44, 8'h99, 4'b0100);
    set_req(2, 1'b0, 1'b0, 8'h00, 8'h00);

    // Sequencer never stops: watchdog abort
    set_req(3, 1'b1, 1'b1, 8'h77, 8'h88);
    f_wait = 0;
    while (bif.seq_enable !== 1'b1 && f_wait < 200) begin
      @(negedge clk);
      f_wait++;
    end
    chk("wd_enable_seen", 32'(bif.seq_enable), 32'd1);
    bif.seq_state = 3'd3;
    hi_cnt = 0;
    done_seen = 4'd0;
    while (bif.seq_enable === 1'b1 && hi_cnt < 100) begin
      hi_cnt++;
      done_seen = done_seen | bif.req_done;
      @(negedge clk);
    end
    chk("wd_enable_cycles", 32'(hi_cnt), 32'(TIMEOUT));
    chk("wd_terr",          32'(bif.timeout_err), 32'd1);
    chk("wd_acq_cleared",   32'({bif.ms6205_addr_acq, bif.ms6205_data_acq}), 32'd0);
    bif.seq_state = 3'd0;
    repeat (3) begin
      done_seen = done_seen | bif.req_done;
      @(negedge clk);
    end
    chk("wd_no_done",  32'(done_seen), 32'd0);
    chk("wd_anode",    32'(bif.anode_index), 32'(exp_anode));

    // Same requester granted again, watchdog flag stays set
    do_frame(5, 1'b0);
    check_frame("wd_regrant", 2'b11, 8'h77, 8'h88, 4'b1000);
    chk("wd_terr_sticky", 32'(bif.timeout_err), 32'd1);

    // Asynchronous reset in the middle of RUN
    f_wait = 0;
    while (bif.seq_enable !== 1'b1 && f_wait < 200) begin
      @(negedge clk);
      f_wait++;
    end
    chk("ar_enable_seen", 32'(bif.seq_enable), 32'd1);
    bif.seq_state = 3'd3;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_enable", 32'(bif.seq_enable),  32'd0);
    chk("ar_acq",    32'({bif.ms6205_addr_acq, bif.ms6205_data_acq}), 32'd0);
    chk("ar_done",   32'(bif.req_done),    32'd0);
    chk("ar_anode",  32'(bif.anode_index), 32'd0);
    chk("ar_terr",   32'(bif.timeout_err), 32'd0);
    exp_anode = 0;
    bif.seq_state = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    do_frame(5, 1'b0);
    chk("ar_first_gap", 32'(f_wait), 32'(IDLE_CYC + 1));
    check_frame("ar_frame", 2'b11, 8'h77, 8'h88, 4'b1000);
    set_req(3, 1'b0, 1'b0, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
